// File: rtl/debug_rom_ctrl.sv
// Multi-image boot debug ROM: checksum self-test after reset, then valid/ready fetches
// with a fixed wait-state latency emulating the SPI memory path.
module debug_rom_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned IMG_DEPTH   = 32,
  parameter int unsigned NUM_IMAGES  = 2,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = "",
  localparam int unsigned SEL_W      = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  img_sel,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              selftest_done,
  output logic              selftest_ok
);

  localparam int unsigned DepthTot = NUM_IMAGES * IMG_DEPTH;
  localparam int unsigned MemAw    = $clog2(DepthTot);
  localparam int unsigned OfsW     = $clog2(IMG_DEPTH);
  localparam int unsigned CntW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned CmpW     = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic [1:0] {StSelftest, StIdle, StWait, StResp} state_e;

  logic [DATA_W-1:0] rom [DepthTot];

  // ROM contents default to zero.
  initial begin
    for (int unsigned i = 0; i < DepthTot; i++) rom[i] = '0;
  end

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  img_q;
  logic [OfsW-1:0]   st_addr_q, st_addr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;
  logic              hit_q, hit_d;
  logic [OfsW-1:0]   ofs_q, ofs_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [MemAw-1:0]  base;
  logic [OfsW-1:0]   rd_ofs;
  logic [DATA_W-1:0] word;
  logic [CmpW-1:0]   addr_ext;
  logic              in_range;

  // One read port, shared by the self-test walk and the fetch path.
  assign base     = MemAw'(img_q) * MemAw'(IMG_DEPTH);
  assign rd_ofs   = (state_q == StSelftest) ? st_addr_q : ofs_q;
  assign word     = rom[base + MemAw'(rd_ofs)];
  assign addr_ext = CmpW'(req_addr);
  assign in_range = addr_ext < CmpW'(IMG_DEPTH);

  always_comb begin
    state_d     = state_q;
    st_addr_d   = st_addr_q;
    sum_d       = sum_q;
    done_d      = done_q;
    ok_d        = ok_q;
    hit_d       = hit_q;
    ofs_d       = ofs_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      StSelftest: begin
        sum_d     = sum_q + word;
        st_addr_d = st_addr_q + OfsW'(1);
        if (st_addr_q == OfsW'(IMG_DEPTH - 1)) begin
          state_d   = StIdle;
          st_addr_d = '0;
          done_d    = 1'b1;
          ok_d      = (sum_d == '0);
        end
      end
      StIdle: begin
        if (req_valid) begin
          hit_d = in_range;
          ofs_d = req_addr[OfsW-1:0];
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            wait_d  = CntW'(WAIT_CYCLES);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        wait_d = wait_q - CntW'(1);
        if (wait_q == CntW'(1)) state_d = StResp;
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = hit_q ? word : '0;
        state_d     = StIdle;
      end
      default: state_d = StSelftest;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_q       <= (32'(img_sel) < NUM_IMAGES) ? img_sel : '0;
      state_q     <= StSelftest;
      st_addr_q   <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      hit_q       <= 1'b0;
      ofs_q       <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      st_addr_q   <= st_addr_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      hit_q       <= hit_d;
      ofs_q       <= ofs_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign selftest_done = done_q;
  assign selftest_ok   = ok_q;

endmodule

// File: tb/tb_debug_rom_ctrl.sv
// Bench for debug_rom_ctrl: one instance with two wait states, one with none.
module tb_debug_rom_ctrl;

  localparam int unsigned Depth = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, img_sel_a, req_valid_a, req_ready_a, rsp_valid_a, busy_a, done_a, ok_a;
  logic [15:0] req_addr_a;
  logic [7:0]  rsp_data_a;
  logic        rst_b, img_sel_b, req_valid_b, req_ready_b, rsp_valid_b, busy_b, done_b, ok_b;
  logic [15:0] req_addr_b;
  logic [7:0]  rsp_data_b;

  debug_rom_ctrl #(.WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .img_sel(img_sel_a), .req_valid(req_valid_a),
    .req_addr(req_addr_a), .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
    .rsp_data(rsp_data_a), .busy(busy_a), .selftest_done(done_a), .selftest_ok(ok_a)
  );

  debug_rom_ctrl #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .img_sel(img_sel_b), .req_valid(req_valid_b),
    .req_addr(req_addr_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_data(rsp_data_b), .busy(busy_b), .selftest_done(done_b), .selftest_ok(ok_b)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] rom0 [Depth];
  logic [7:0] rom1 [Depth];
  logic [7:0] exp_q_a [$];
  logic [7:0] exp_q_b [$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;
  vec_t vecs [9];
  vec_t vecs1 [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Response scoreboards: every rsp_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rsp_valid_a) begin
      checks++;
      if (exp_q_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_rsp actual=%0h required=none", rsp_data_a);
      end else if (rsp_data_a !== exp_q_a[0]) begin
        failures++;
        $display("FAIL a_rsp_data actual=%0h required=%0h", rsp_data_a, exp_q_a[0]);
      end
      if (exp_q_a.size() != 0) void'(exp_q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rsp_valid_b) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_rsp actual=%0h required=none", rsp_data_b);
      end else if (rsp_data_b !== exp_q_b[0]) begin
        failures++;
        $display("FAIL b_rsp_data actual=%0h required=%0h", rsp_data_b, exp_q_b[0]);
      end
      if (exp_q_b.size() != 0) void'(exp_q_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_a = 1'b1; img_sel_a = 1'b0; req_valid_a = 1'b0; req_addr_a = '0;
    rst_b = 1'b1; img_sel_b = 1'b0; req_valid_b = 1'b0; req_addr_b = '0;
    for (int i = 0; i < Depth; i++) begin
      rom0[i] = (i < 31) ? 8'(i + 1) : 8'h10;
      rom1[i] = (i == 5) ? 8'h01 : 8'h00;
    end
    vecs[0] = '{16'h0000, 8'h01};
    vecs[1] = '{16'h0003, 8'h04};
    vecs[2] = '{16'h001E, 8'h1F};
    vecs[3] = '{16'h001F, 8'h10};
    vecs[4] = '{16'h0020, 8'h00};
    vecs[5] = '{16'h0023, 8'h00};
    vecs[6] = '{16'hFFFF, 8'h00};
    vecs[7] = '{16'h0100, 8'h00};
    vecs[8] = '{16'h0011, 8'h12};
    vecs1[0] = '{16'h0005, 8'h01};
    vecs1[1] = '{16'h0004, 8'h00};
    #1;
    for (int i = 0; i < Depth; i++) begin
      dut_a.rom[i] = rom0[i];
      dut_a.rom[Depth + i] = rom1[i];
      dut_b.rom[i] = rom0[i];
      dut_b.rom[Depth + i] = rom1[i];
    end

    repeat (3) @(negedge clk);
    check("a_rst_ready", req_ready_a, 0);
    check("a_rst_rsp_valid", rsp_valid_a, 0);
    check("a_rst_rsp_data", rsp_data_a, 0);
    check("a_rst_busy", busy_a, 1);
    check("a_rst_done", done_a, 0);
    check("a_rst_ok", ok_a, 0);

    // Self-test over image 0 must finish exactly after edge 32.
    rst_a = 1'b0;
    repeat (31) @(negedge clk);
    check("a_st_done_e31", done_a, 0);
    check("a_st_ready_e31", req_ready_a, 0);
    @(negedge clk);
    check("a_st_done_e32", done_a, 1);
    check("a_st_ok_e32", ok_a, 1);
    check("a_st_ready_e32", req_ready_a, 1);
    check("a_st_busy_e32", busy_a, 0);

    // Exact latency with two wait states; a request held during WAIT/RESP is ignored.
    req_valid_a = 1'b1; req_addr_a = 16'h0003; exp_q_a.push_back(8'h04);
    @(negedge clk);
    req_addr_a = 16'h001E;
    check("a_lat_ready_w1", req_ready_a, 0);
    check("a_lat_valid_w1", rsp_valid_a, 0);
    @(negedge clk);
    check("a_lat_ready_w2", req_ready_a, 0);
    check("a_lat_valid_w2", rsp_valid_a, 0);
    @(negedge clk);
    check("a_lat_ready_resp", req_ready_a, 0);
    check("a_lat_busy_resp", busy_a, 1);
    check("a_lat_valid_resp", rsp_valid_a, 0);
    req_valid_a = 1'b0;
    @(negedge clk);
    check("a_lat_valid_n3", rsp_valid_a, 1);
    check("a_lat_ready_n3", req_ready_a, 1);
    @(negedge clk);
    check("a_lat_valid_n4", rsp_valid_a, 0);
    check("a_lat_hold_data", rsp_data_a, 8'h04);

    foreach (vecs[k]) begin
      n = 0;
      while (!req_ready_a && n < 20) begin @(negedge clk); n++; end
      check("a_vec_ready", req_ready_a, 1);
      req_valid_a = 1'b1; req_addr_a = vecs[k].addr; exp_q_a.push_back(vecs[k].data);
      @(negedge clk);
      req_valid_a = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("a_vec_drained", exp_q_a.size(), 0);

    // Reset one cycle after an accept: fetch dropped, self-test reruns on image 1.
    req_valid_a = 1'b1; req_addr_a = 16'h0003;
    @(negedge clk);
    req_valid_a = 1'b0; rst_a = 1'b1; img_sel_a = 1'b1;
    @(negedge clk);
    check("a_midrst_busy", busy_a, 1);
    check("a_midrst_done", done_a, 0);
    check("a_midrst_valid", rsp_valid_a, 0);
    rst_a = 1'b0;
    n = 0;
    while (!done_a && n < 40) begin @(negedge clk); n++; end
    check("a_rerun_edges", n, 32);
    check("a_rerun_ok_bad_img", ok_a, 0);
    check("a_rerun_ready", req_ready_a, 1);
    foreach (vecs1[k]) begin
      n = 0;
      while (!req_ready_a && n < 20) begin @(negedge clk); n++; end
      check("a_img1_ready", req_ready_a, 1);
      req_valid_a = 1'b1; req_addr_a = vecs1[k].addr; exp_q_a.push_back(vecs1[k].data);
      @(negedge clk);
      req_valid_a = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("a_img1_drained", exp_q_a.size(), 0);

    // Zero wait states, request held high, img_sel toggling outside reset.
    check("b_rst_busy", busy_b, 1);
    check("b_rst_ready", req_ready_b, 0);
    rst_b = 1'b0;
    n = 0;
    while (!done_b && n < 40) begin @(negedge clk); n++; end
    check("b_st_edges", n, 32);
    check("b_st_ok", ok_b, 1);
    req_valid_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr_b = 16'(i);
      img_sel_b = i[0];
      check("b_stream_ready", req_ready_b, (i % 2) == 0);
      check("b_stream_valid", rsp_valid_b, (i >= 2) && ((i % 2) == 0));
      if ((i % 2) == 0) exp_q_b.push_back(rom0[i]);
      @(negedge clk);
    end
    req_valid_b = 1'b0;
    repeat (4) @(negedge clk);
    check("b_stream_drained", exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
